// File: rtl/vga_game_pkg.sv
// Shared definitions for the VGA square game: FSM state encoding and the
// default playfield geometry used by the motion controller.
package vga_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_SCORED = 2'd2
  } state_t;

  localparam int Y_START_DEF = 200;
  localparam int Y_MIN_DEF   = 100;
  localparam int Y_MAX_DEF   = 435;
  localparam int HIT_LO_DEF  = 360;
  localparam int HIT_HI_DEF  = 435;
  localparam int REARM_Y_DEF = 140;
  localparam int SQUARE_H    = 40;

  localparam logic [15:0] SCORE_MAX = 16'hFFFF;

  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/square_motion_ctrl_btn_sync.sv
// Two-flop synchronizer for an asynchronous push button, plus a one-cycle
// rising-edge pulse derived from the synchronized level.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic sync1, sync2, prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign level = sync2;
  assign rise  = sync2 & ~prev;

endmodule

// File: rtl/square_motion_ctrl.sv
// Square motion and scoring controller. Optional build macro:
// SQUARE_AUTO_FALL_EN makes the square drift down one row per tick when idle.
module square_motion_ctrl
  import vga_game_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int Y_START  = Y_START_DEF,
  parameter int Y_MIN    = Y_MIN_DEF,
  parameter int Y_MAX    = Y_MAX_DEF,
  parameter int HIT_LO   = HIT_LO_DEF,
  parameter int HIT_HI   = HIT_HI_DEF,
  parameter int REARM_Y  = REARM_Y_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BtnU,
  input  logic        BtnD,
  input  logic        BtnC,
  output logic [9:0]  square_y,
  output logic [15:0] score,
  output logic [1:0]  state,
  output logic        hit
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [9:0] YS  = 10'(Y_START);
  localparam logic [9:0] YLO = 10'(Y_MIN);
  localparam logic [9:0] YHI = 10'(Y_MAX);
  localparam logic [9:0] HLO = 10'(HIT_LO);
  localparam logic [9:0] HHI = 10'(HIT_HI);
  localparam logic [9:0] RAY = 10'(REARM_Y);

  logic up, down, btnc_rise, up_rise_unused, down_rise_unused, c_level_unused;

  btn_sync u_btn_u (.clk(clk), .reset(reset), .btn(BtnU), .level(up),   .rise(up_rise_unused));
  btn_sync u_btn_d (.clk(clk), .reset(reset), .btn(BtnD), .level(down), .rise(down_rise_unused));
  btn_sync u_btn_c (.clk(clk), .reset(reset), .btn(BtnC), .level(c_level_unused), .rise(btnc_rise));

  state_t        state_q, next_state;
  logic [9:0]    y_q, y_next, moved_y;
  logic [15:0]   score_q, score_next;
  logic          hit_q, hit_next;
  logic [CW-1:0] cnt_q;
  logic          tick;

  // Motion pacing: free-runs only while a game is in progress.
  always_ff @(posedge clk) begin
    if (reset || state_q == ST_IDLE) cnt_q <= '0;
    else if (cnt_q == CNT_LAST)      cnt_q <= '0;
    else                             cnt_q <= cnt_q + 1'b1;
  end

  assign tick = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);

  // NOTE: every combinational output gets a default first, so no path through
  // the block can leave a signal unassigned and infer a latch.
  always_comb begin
    moved_y = y_q;
    if (tick) begin
      if (up && !down && y_q < YHI)       moved_y = y_q + 10'd1;
      else if (down && !up && y_q > YLO)  moved_y = y_q - 10'd1;
`ifdef SQUARE_AUTO_FALL_EN
      else if (!up && !down && y_q > YLO) moved_y = y_q - 10'd1;
`endif
    end
  end

  // Scoring and rearm decisions look at y_q, i.e. the row before this cycle's move.
  always_comb begin
    next_state = state_q;
    y_next     = y_q;
    score_next = score_q;
    hit_next   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        y_next = YS;
        if (btnc_rise) next_state = ST_ARMED;
      end
      ST_ARMED: begin
        y_next = moved_y;
        if (btnc_rise && in_range(y_q, HLO, HHI)) begin
          next_state = ST_SCORED;
          hit_next   = 1'b1;
          if (score_q != SCORE_MAX) score_next = score_q + 16'd1;
        end
      end
      ST_SCORED: begin
        y_next = moved_y;
        if (y_q <= RAY) next_state = ST_ARMED;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= YS;
      score_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= next_state;
      y_q     <= y_next;
      score_q <= score_next;
      hit_q   <= hit_next;
    end
  end

  assign square_y = y_q;
  assign score    = score_q;
  assign state    = state_q;
  assign hit      = hit_q;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Self-checking bench for square_motion_ctrl: directed vector table, a
// saturation/reset sequence, and randomized play against a behavioural model.
module tb_square_motion_ctrl;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset, BtnU, BtnD, BtnC;
  logic [9:0]  square_y;
  logic [15:0] score;
  logic [1:0]  state;
  logic        hit;

  always #5 clk = ~clk;

  square_motion_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC),
    .square_y(square_y), .score(score), .state(state), .hit(hit)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int u, d, c, r, n;
    int st, y, sc, h;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: game rules on plain integers, buttons seen through a
  // two-cycle delay and C edges taken from that delayed stream.
  int m_st, m_y, m_sc, m_h, m_cnt;
  bit m_u1, m_u2, m_d1, m_d2, m_c1, m_c2, m_c3;

  task automatic model_reset();
    m_st = 0; m_y = 200; m_sc = 0; m_h = 0; m_cnt = 0;
    m_u1 = 0; m_u2 = 0; m_d1 = 0; m_d2 = 0; m_c1 = 0; m_c2 = 0; m_c3 = 0;
  endtask

  task automatic model_step(input bit u, input bit d, input bit c, input bit r);
    int  ny   = m_y;
    int  nst  = m_st;
    int  nsc  = m_sc;
    int  nh   = 0;
    int  ncnt = 0;
    bit  tick = (m_st != 0) && (m_cnt == TD - 1);
    bit  rise = m_c2 && !m_c3;
    if (r) begin
      model_reset();
      return;
    end
    if (m_st == 0) begin
      ny = 200;
      if (rise) nst = 1;
    end else begin
      ncnt = (m_cnt + 1) % TD;
      if (m_st == 1 && rise && m_y >= 360 && m_y <= 435) begin
        nst = 2;
        nh  = 1;
        nsc = (m_sc < 65535) ? m_sc + 1 : 65535;
      end else if (m_st == 2 && m_y <= 140) begin
        nst = 1;
      end
      if (tick) begin
        if (m_u2 && !m_d2)      ny = (m_y + 1 > 435) ? 435 : m_y + 1;
        else if (m_d2 && !m_u2) ny = (m_y - 1 < 100) ? 100 : m_y - 1;
`ifdef SQUARE_AUTO_FALL_EN
        else if (!m_u2 && !m_d2) ny = (m_y - 1 < 100) ? 100 : m_y - 1;
`endif
      end
    end
    m_c3 = m_c2; m_c2 = m_c1; m_c1 = c;
    m_u2 = m_u1; m_u1 = u;
    m_d2 = m_d1; m_d1 = d;
    m_st = nst; m_y = ny; m_sc = nsc; m_h = nh; m_cnt = ncnt;
  endtask

  initial begin
    int hits;
    int mode;
    bit ru, rd, rc, rr;

    reset = 1'b1; BtnU = 1'b0; BtnD = 1'b0; BtnC = 1'b0;

    //              u  d  c  r  n     st  y    sc  h
    tbl.push_back('{0, 0, 0, 1, 2,    0, 200, 0, 0});  // reset state
    tbl.push_back('{0, 0, 1, 0, 3,    1, 200, 0, 0});  // start press -> ARMED
    tbl.push_back('{1, 0, 0, 0, 16,   1, 204, 0, 0});  // 4 ticks up
    tbl.push_back('{1, 1, 0, 0, 20,   1, 204, 0, 0});  // both held, 5 ticks
    tbl.push_back('{1, 0, 0, 0, 784,  1, 400, 0, 0});  // climb to 400
    tbl.push_back('{0, 0, 1, 0, 3,    2, 400, 1, 1});  // score in window
    tbl.push_back('{0, 0, 1, 0, 1,    2, 400, 1, 0});  // hit lasts one cycle
    tbl.push_back('{0, 0, 0, 0, 4,    2, 400, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 4,    2, 400, 1, 0});  // second press ignored
    tbl.push_back('{0, 1, 0, 0, 1041, 1, 140, 1, 0});  // descend, rearm at 140
    tbl.push_back('{0, 1, 0, 0, 171,  1, 100, 1, 0});  // pinned at Y_MIN
    tbl.push_back('{0, 0, 1, 0, 3,    1, 100, 1, 0});  // press outside window
    tbl.push_back('{1, 0, 0, 0, 1353, 1, 435, 1, 0});  // pinned at Y_MAX
    tbl.push_back('{0, 0, 1, 0, 3,    2, 435, 2, 1});  // HIT_HI is inclusive
    tbl.push_back('{0, 1, 0, 0, 1182, 1, 140, 2, 0});  // back down, rearm
    tbl.push_back('{1, 0, 0, 0, 639,  1, 300, 2, 0});  // climb to 300
    tbl.push_back('{0, 0, 1, 0, 3,    1, 300, 2, 0});  // miss at 300
    tbl.push_back('{0, 0, 0, 1, 1,    0, 200, 0, 0});  // reset mid-game

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      BtnU  = tbl[i].u[0];
      BtnD  = tbl[i].d[0];
      BtnC  = tbl[i].c[0];
      reset = tbl[i].r[0];
      repeat (tbl[i].n) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_state", i), 32'(state),    tbl[i].st);
      check($sformatf("vec%0d_y", i),     32'(square_y), tbl[i].y);
      check($sformatf("vec%0d_score", i), 32'(score),    tbl[i].sc);
      check($sformatf("vec%0d_hit", i),   32'(hit),      tbl[i].h);
    end

    // Saturated score: a valid hit still pulses and enters SCORED.
    reset = 1'b0; BtnC = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sat_armed", 32'(state), 1);
    BtnC = 1'b0; BtnU = 1'b1;
    for (int k = 0; k < 2000 && square_y != 10'd400; k++) @(negedge clk);
    check("sat_climb_to_400", 32'(square_y), 400);
    BtnU = 1'b0;
    repeat (4) @(negedge clk);
    force dut.score_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.score_q;
    BtnC = 1'b1;
    hits = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (hit === 1'b1) hits++;
    end
    check("sat_hit_pulses", 32'(hits), 1);
    check("sat_score_held", 32'(score), 32'hFFFF);
    check("sat_state", 32'(state), 2);

    // Reset while moving and pressing wins over everything else.
    BtnC = 1'b0; BtnD = 1'b1;
    repeat (10) @(negedge clk);
    BtnC = 1'b1; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_y", 32'(square_y), 200);
    check("rst_score", 32'(score), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_cnt", 32'(dut.cnt_q), 0);

    // Randomized play against the model.
    BtnU = 1'b0; BtnD = 1'b0; BtnC = 1'b0; reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    mode = 0;
    rc = 0;
    for (int i = 0; i < 8000; i++) begin
      if (i % 400 == 0) mode = (i < 1200) ? 0 : int'($urandom_range(0, 2));
      case (mode)
        0:       begin ru = ($urandom_range(0, 9) < 8); rd = ($urandom_range(0, 9) < 1); end
        1:       begin ru = ($urandom_range(0, 9) < 1); rd = ($urandom_range(0, 9) < 8); end
        default: begin ru = $urandom_range(0, 1) != 0; rd = $urandom_range(0, 1) != 0; end
      endcase
      if ($urandom_range(0, 7) == 0) rc = ~rc;
      rr = ($urandom_range(0, 2999) == 0);
      BtnU = ru; BtnD = rd; BtnC = rc; reset = rr;
      model_step(ru, rd, rc, rr);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rnd%0d_state", i), 32'(state),    m_st);
      check($sformatf("rnd%0d_y", i),     32'(square_y), m_y);
      check($sformatf("rnd%0d_score", i), 32'(score),    m_sc);
      check($sformatf("rnd%0d_hit", i),   32'(hit),      m_h);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
